// File: rtl/sram_controller.sv
// Memory-stage load/store responder: each 32-bit access is split into two 16-bit SRAM phases (LO, HI).
// Define SRAM_ADDR_CHECK_EN to reject out-of-window or misaligned requests via addr_err.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int unsigned CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned WORD_W = 17;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [17:0]       sram_addr_q, sram_addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;

    logic              req_c;
    logic              last_c;
    logic              half_c;
    logic              reject_c;
    logic [WORD_W-1:0] word_c;

    assign req_c  = mem_r_en | mem_w_en;
    assign last_c = (cnt_q == CNT_LAST);
    // Word index inside the SRAM window; the subtraction wraps modulo 2^32.
    assign word_c = WORD_W'((address - BASE) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;

    assign reject_c = (address < BASE) || (address[1:0] != 2'b00)
                   || ((address - BASE) >= 32'h0008_0000);
    assign addr_err = addr_err_q;
`else
    assign reject_c = 1'b0;
    assign addr_err = 1'b0;
`endif

    // Next-state, request latch, read capture and registered SRAM drive values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr_d = 18'd0;
        dq_out_d    = 16'd0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        half_c      = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
        addr_err_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    word_d  = word_c;
                    wr_d    = mem_w_en;
                    wdata_d = write_data;
                    cnt_d   = CNT_W'(0);
                    if (reject_c) begin
                        state_d = ST_DONE;
`ifdef SRAM_ADDR_CHECK_EN
                        addr_err_d = 1'b1;
`endif
                        if (!mem_w_en) begin
                            rdata_d = 32'd0;
                        end
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (last_c) begin
                    state_d = ST_HI;
                    cnt_d   = CNT_W'(0);
                    if (!wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_HI: begin
                if (last_c) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_W'(0);
                    if (!wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM port values are computed from the upcoming state so they register cleanly.
        if ((state_d == ST_LO) || (state_d == ST_HI)) begin
            half_c      = (state_d == ST_HI);
            sram_addr_d = {word_d, half_c};
            if (wr_d) begin
                dq_oe_d  = 1'b1;
                we_n_d   = 1'b0;
                dq_out_d = half_c ? wdata_d[31:16] : wdata_d[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_W'(0);
            word_q      <= WORD_W'(0);
            wr_q        <= 1'b0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= 18'd0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end
`endif

    // Pipeline freeze is ~ready, so a freshly presented request must pull ready low at once.
    assign ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req_c);
    assign read_data   = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench for sram_controller against a word-level memory model.
module tb_sram_controller;

    localparam int unsigned BASE = 1024;
    localparam int unsigned H    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] sram_mem [0:262143];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] exp_rdata;
    logic [31:0] pool [8];

    sram_controller #(
        .BASE_ADDR   (BASE),
        .HOLD_CYCLES (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .addr_err    (addr_err),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write on clock edge while we_n is low.
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end
    end

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 4) % 131072;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full request from the cycle it appears (cycle 0) through DONE (cycle 2H+1).
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int unsigned w;
        logic        hi;
        logic [31:0] hw;
        w = widx(a);
        @(negedge clk);
        mem_r_en   = rd;
        mem_w_en   = wr;
        address    = a;
        write_data = wd;
        #1;
        check("ready_on_req", 32'(ready), 32'd0);
        check("we_n_cycle0", 32'(sram_we_n), 32'd1);
        for (int k = 1; k <= 2 * H + 1; k++) begin
            @(negedge clk);
            if (k <= 2 * H) begin
                hi = (k > H);
                hw = w * 2 + (hi ? 1 : 0);
                check("ready_busy", 32'(ready), 32'd0);
                check("sram_addr", 32'(sram_addr), hw);
                if (wr) begin
                    check("we_n_wr", 32'(sram_we_n), 32'd0);
                    check("oe_wr", 32'(sram_dq_oe), 32'd1);
                    check("dq_out", 32'(sram_dq_out), hi ? (wd >> 16) : (wd & 32'hFFFF));
                end else begin
                    check("we_n_rd", 32'(sram_we_n), 32'd1);
                    check("oe_rd", 32'(sram_dq_oe), 32'd0);
                end
            end else begin
                check("ready_done", 32'(ready), 32'd1);
                check("we_n_done", 32'(sram_we_n), 32'd1);
                check("oe_done", 32'(sram_dq_oe), 32'd0);
                check("addr_done", 32'(sram_addr), 32'd0);
                check("addr_err_done", 32'(addr_err), 32'd0);
                if (!wr) begin
                    exp_rdata = ref_mem[w];
                end
                check("read_data", read_data, exp_rdata);
            end
        end
        if (wr) begin
            ref_mem[w] = wd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
            #1;
            check("ready_idle", 32'(ready), 32'd1);
            check("we_n_idle", 32'(sram_we_n), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          op;
        rst        = 1'b1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        exp_rdata  = 32'd0;
        for (int i = 0; i < 8; i++) begin
            pool[i] = BASE + 4 * (i * 37 + 5);
        end

        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0;
        idle(1);

        // Directed store then back-to-back load of the same word.
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'd0);
        check("load_deadbeef", read_data, 32'hDEADBEEF);
        idle(1);

        // Both enables high: treated as a store, read_data left alone.
        access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        check("both_rdata_kept", read_data, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'd0);
        check("both_wrote", read_data, 32'h12345678);

`ifdef SRAM_ADDR_CHECK_EN
        @(negedge clk);
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        address  = 32'd512;
        #1;
        check("rej_ready_c0", 32'(ready), 32'd0);
        @(negedge clk);
        check("rej_ready", 32'(ready), 32'd1);
        check("rej_addr_err", 32'(addr_err), 32'd1);
        check("rej_we_n", 32'(sram_we_n), 32'd1);
        check("rej_oe", 32'(sram_dq_oe), 32'd0);
        check("rej_read_data", read_data, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        mem_r_en = 1'b0;
        #1;
        check("rej_addr_err_clr", 32'(addr_err), 32'd0);
        check("rej_we_n_after", 32'(sram_we_n), 32'd1);
`else
        // Misaligned alias 2^19 above the window hits the same word; wrap below BASE lands high.
        access(1'b0, 1'b1, 32'd1028 + 32'h0008_0000 + 32'd2, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'd1028, 32'd0);
        check("alias_load", read_data, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'd512, 32'h0BADC0DE);
        access(1'b1, 1'b0, BASE + 32'h0007_FE00, 32'd0);
        check("wrap_load", read_data, 32'h0BADC0DE);
`endif

        // Reset asserted while the HI half of a store is on the port.
        @(negedge clk);
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b1;
        address    = pool[0];
        write_data = 32'hA5A55A5A;
        for (int k = 1; k <= H + 1; k++) begin
            @(negedge clk);
        end
        check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        #1;
        rst      = 1'b1;
        mem_w_en = 1'b0;
        #1;
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_oe", 32'(sram_dq_oe), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_read_data", read_data, 32'd0);
        check("midrst_addr", 32'(sram_addr), 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Initialise every pool word, then a random mix of loads/stores with random gaps.
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b1, pool[i], $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            d  = $urandom;
            case (op)
                0:       access(1'b1, 1'b0, pool[$urandom_range(0, 7)], d);
                1:       access(1'b0, 1'b1, pool[$urandom_range(0, 7)], d);
                default: access(1'b1, 1'b1, pool[$urandom_range(0, 7)], d);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 2));
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
